alu_power_ctrl: RTL and testbench

//  Power-sequencing controller that produces alu_pwr_en and iso_en for the gated ALU domain.
//  It honours a level power request from system software or a PMU.

---
 rtl/alu_pwr_pkg.sv | 52 +++++
 rtl/pwr_seq_timer.sv | 39 +++
 rtl/alu_power_ctrl.sv | 112 +++++++++++
 tb/tb_alu_power_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pwr_pkg.sv
// Shared types and constants for the ALU power-domain sequencer.
// The state encoding doubles as the externally visible pwr_state status value.
package alu_pwr_pkg;

    localparam int PWR_STATE_W = 3;

    localparam int unsigned DEF_ISO_SETUP_CYC = 32'd4;
    localparam int unsigned DEF_PWR_DN_CYC    = 32'd8;
    localparam int unsigned DEF_PWR_UP_CYC    = 32'd16;
    localparam int unsigned DEF_ISO_HOLD_CYC  = 32'd2;

    typedef enum logic [PWR_STATE_W-1:0] {
        ST_OFF      = 3'd0,
        ST_PWR_UP   = 3'd1,
        ST_ISO_REL  = 3'd2,
        ST_ON       = 3'd3,
        ST_ISO_SET  = 3'd4,
        ST_OFF_WAIT = 3'd5
    } pwr_state_e;

    typedef struct packed {
        logic pwr;
        logic iso;
        logic ready;
    } pwr_out_t;

    // Output triple for each state; unknown codes fall back to the safe OFF values.
    function automatic pwr_out_t state_outputs(input pwr_state_e st);
        pwr_out_t o;
        case (st)
            ST_OFF:      begin o.pwr = 1'b0; o.iso = 1'b1; o.ready = 1'b0; end
            ST_PWR_UP:   begin o.pwr = 1'b1; o.iso = 1'b1; o.ready = 1'b0; end
            ST_ISO_REL:  begin o.pwr = 1'b1; o.iso = 1'b0; o.ready = 1'b0; end
            ST_ON:       begin o.pwr = 1'b1; o.iso = 1'b0; o.ready = 1'b1; end
            ST_ISO_SET:  begin o.pwr = 1'b1; o.iso = 1'b1; o.ready = 1'b0; end
            ST_OFF_WAIT: begin o.pwr = 1'b0; o.iso = 1'b1; o.ready = 1'b0; end
            default:     begin o.pwr = 1'b0; o.iso = 1'b1; o.ready = 1'b0; end
        endcase
        return o;
    endfunction

    function automatic int unsigned max_cyc(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/pwr_seq_timer.sv
// Per-state dwell counter: restarts at zero on clr, otherwise counts up and
// saturates at all-ones; tc flags that the count has reached target.
module pwr_seq_timer #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [WIDTH-1:0] target,
    output logic             tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear wins, then increment unless already saturated.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = {WIDTH{1'b0}};
        end else if (!(&count_q)) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == target);

endmodule

// File: rtl/alu_power_ctrl.sv
// Power-sequencing FSM for the gated ALU domain: isolation is always applied
// before power is removed and released only after power has ramped.
module alu_power_ctrl
    import alu_pwr_pkg::*;
#(
    parameter int unsigned ISO_SETUP_CYC = DEF_ISO_SETUP_CYC,
    parameter int unsigned PWR_DN_CYC    = DEF_PWR_DN_CYC,
    parameter int unsigned PWR_UP_CYC    = DEF_PWR_UP_CYC,
    parameter int unsigned ISO_HOLD_CYC  = DEF_ISO_HOLD_CYC
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pwr_req,
    input  logic                   alu_busy,
    output logic                   alu_pwr_en,
    output logic                   iso_en,
    output logic                   alu_ready,
    output logic                   pwr_done,
    output logic [PWR_STATE_W-1:0] pwr_state
);

    localparam int unsigned TMR_W =
        $clog2(max_cyc(ISO_SETUP_CYC, PWR_DN_CYC, PWR_UP_CYC, ISO_HOLD_CYC)) + 1;

    pwr_state_e       state_q, state_d;
    pwr_out_t         out_d;
    logic             alu_pwr_en_q, iso_en_q, alu_ready_q, pwr_done_q;
    logic             pwr_done_d;
    logic             tmr_clr_s;
    logic             tmr_tc_s;
    logic [TMR_W-1:0] tmr_target_s;

    // Next-state and dwell-target selection; timed states never abort early.
    always_comb begin
        state_d      = state_q;
        tmr_target_s = {TMR_W{1'b0}};
        case (state_q)
            ST_OFF: begin
                if (pwr_req) state_d = ST_PWR_UP;
                else         state_d = ST_OFF;
            end
            ST_PWR_UP: begin
                tmr_target_s = TMR_W'(PWR_UP_CYC - 32'd1);
                if (tmr_tc_s) state_d = ST_ISO_REL;
                else          state_d = ST_PWR_UP;
            end
            ST_ISO_REL: begin
                tmr_target_s = TMR_W'(ISO_HOLD_CYC - 32'd1);
                if (tmr_tc_s) state_d = ST_ON;
                else          state_d = ST_ISO_REL;
            end
            ST_ON: begin
                if (!pwr_req && !alu_busy) state_d = ST_ISO_SET;
                else                       state_d = ST_ON;
            end
            ST_ISO_SET: begin
                tmr_target_s = TMR_W'(ISO_SETUP_CYC - 32'd1);
                if (tmr_tc_s) state_d = ST_OFF_WAIT;
                else          state_d = ST_ISO_SET;
            end
            ST_OFF_WAIT: begin
                tmr_target_s = TMR_W'(PWR_DN_CYC - 32'd1);
                if (tmr_tc_s) state_d = ST_OFF;
                else          state_d = ST_OFF_WAIT;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_comb begin
        out_d      = state_outputs(state_d);
        tmr_clr_s  = (state_d != state_q);
        pwr_done_d = tmr_clr_s && ((state_d == ST_ON) || (state_d == ST_OFF));
    end

    // State and registered output flops; reset forces the clamped, unpowered values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_OFF;
            alu_pwr_en_q <= 1'b0;
            iso_en_q     <= 1'b1;
            alu_ready_q  <= 1'b0;
            pwr_done_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            alu_pwr_en_q <= out_d.pwr;
            iso_en_q     <= out_d.iso;
            alu_ready_q  <= out_d.ready;
            pwr_done_q   <= pwr_done_d;
        end
    end

    pwr_seq_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr_s),
        .target (tmr_target_s),
        .tc     (tmr_tc_s)
    );

    assign alu_pwr_en = alu_pwr_en_q;
    assign iso_en     = iso_en_q;
    assign alu_ready  = alu_ready_q;
    assign pwr_done   = pwr_done_q;
    assign pwr_state  = state_q;

endmodule

// File: tb/tb_alu_power_ctrl.sv
// Self-checking bench for alu_power_ctrl: directed sequences with literal
// expectations plus a segment-queue reference model compared every cycle.
module tb_alu_power_ctrl;

    localparam int ISO_SETUP = 4;
    localparam int PWR_DN    = 8;
    localparam int PWR_UP    = 16;
    localparam int ISO_HOLD  = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwr_req  = 1'b0;
    logic       alu_busy = 1'b0;
    logic       alu_pwr_en, iso_en, alu_ready, pwr_done;
    logic [2:0] pwr_state;

    int checks = 0;
    int errors = 0;
    int dut_done_cnt = 0;

    alu_power_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pwr_req    (pwr_req),
        .alu_busy   (alu_busy),
        .alu_pwr_en (alu_pwr_en),
        .iso_en     (iso_en),
        .alu_ready  (alu_ready),
        .pwr_done   (pwr_done),
        .pwr_state  (pwr_state)
    );

    always #5 clk = ~clk;

    // Reference model: the current phase and how many cycles of it remain.
    // Phase codes follow the status encoding (0 OFF .. 5 OFF_WAIT).
    bit exp_pwr [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_iso [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    bit exp_rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int m_state = 0;
    int m_left  = 0;
    bit m_done  = 1'b0;
    int m_completions = 0;

    function automatic int phase_after(input int p);
        case (p)
            1: return 2;
            2: return 3;
            4: return 5;
            5: return 0;
            default: return 0;
        endcase
    endfunction

    function automatic int phase_len(input int p);
        case (p)
            1: return PWR_UP;
            2: return ISO_HOLD;
            4: return ISO_SETUP;
            5: return PWR_DN;
            default: return 0;
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_left  <= 0;
            m_done  <= 1'b0;
        end else begin
            m_done <= 1'b0;
            if (m_state == 0) begin
                if (pwr_req) begin
                    m_state <= 1;
                    m_left  <= PWR_UP;
                end
            end else if (m_state == 3) begin
                if (!pwr_req && !alu_busy) begin
                    m_state <= 4;
                    m_left  <= ISO_SETUP;
                end
            end else if (m_left > 1) begin
                m_left <= m_left - 1;
            end else begin
                m_state <= phase_after(m_state);
                m_left  <= phase_len(phase_after(m_state));
                if (phase_after(m_state) == 0 || phase_after(m_state) == 3) begin
                    m_done        <= 1'b1;
                    m_completions <= m_completions + 1;
                end
            end
        end
    end

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Per-cycle comparison against the model and the safety invariants.
    task automatic compare_loop();
        forever begin
            @(negedge clk);
            chk("m_state", int'(pwr_state), m_state);
            chk("m_pwr", int'(alu_pwr_en), int'(exp_pwr[m_state]));
            chk("m_iso", int'(iso_en), int'(exp_iso[m_state]));
            chk("m_ready", int'(alu_ready), int'(exp_rdy[m_state]));
            chk("m_done", int'(pwr_done), int'(m_done));
            chk("inv_iso_when_off", int'(!alu_pwr_en && !iso_en), 0);
            chk("inv_ready_safe", int'(alu_ready && !(alu_pwr_en && !iso_en)), 0);
            if (pwr_done) dut_done_cnt++;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        fork
            compare_loop();
        join_none
        step(3);
        rst_n = 1'b1;

        // 1: idle in OFF with no request
        step(20);
        chk("t1_pwr", int'(alu_pwr_en), 0);
        chk("t1_iso", int'(iso_en), 1);
        chk("t1_ready", int'(alu_ready), 0);
        chk("t1_state", int'(pwr_state), 0);

        // 2: full power-up with default timing
        pwr_req = 1'b1;
        step(1);
        chk("t2_pwr_rise", int'(alu_pwr_en), 1);
        chk("t2_iso_held", int'(iso_en), 1);
        chk("t2_state_up", int'(pwr_state), 1);
        step(15);
        chk("t2_iso_still", int'(iso_en), 1);
        step(1);
        chk("t2_iso_fall", int'(iso_en), 0);
        chk("t2_state_rel", int'(pwr_state), 2);
        chk("t2_ready_early", int'(alu_ready), 0);
        step(1);
        chk("t2_ready_wait", int'(alu_ready), 0);
        step(1);
        chk("t2_ready", int'(alu_ready), 1);
        chk("t2_done", int'(pwr_done), 1);
        chk("t2_state_on", int'(pwr_state), 3);
        step(1);
        chk("t2_done_pulse", int'(pwr_done), 0);

        // 3: power-down request held off by busy
        pwr_req  = 1'b0;
        alu_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("t3_busy_on", int'(pwr_state), 3);
        end
        alu_busy = 1'b0;
        step(1);
        chk("t3_state_set", int'(pwr_state), 4);
        chk("t3_iso_rise", int'(iso_en), 1);
        chk("t3_pwr_held", int'(alu_pwr_en), 1);
        step(3);
        chk("t3_pwr_still", int'(alu_pwr_en), 1);
        step(1);
        chk("t3_pwr_fall", int'(alu_pwr_en), 0);
        chk("t3_state_wait", int'(pwr_state), 5);
        step(7);
        chk("t3_state_wait2", int'(pwr_state), 5);
        step(1);
        chk("t3_state_off", int'(pwr_state), 0);
        chk("t3_done", int'(pwr_done), 1);

        // 4: short request still completes both sequences
        pwr_req = 1'b1;
        step(3);
        pwr_req = 1'b0;
        step(16);
        chk("t4_state_on", int'(pwr_state), 3);
        chk("t4_ready", int'(alu_ready), 1);
        step(1);
        chk("t4_state_set", int'(pwr_state), 4);
        chk("t4_ready_drop", int'(alu_ready), 0);
        step(4);
        chk("t4_state_wait", int'(pwr_state), 5);
        step(8);
        chk("t4_state_off", int'(pwr_state), 0);
        chk("t4_done", int'(pwr_done), 1);

        // 5: asynchronous reset in the middle of power-up
        pwr_req = 1'b1;
        step(8);
        chk("t5_pre_state", int'(pwr_state), 1);
        rst_n = 1'b0;
        #1;
        chk("t5_pwr", int'(alu_pwr_en), 0);
        chk("t5_iso", int'(iso_en), 1);
        chk("t5_state", int'(pwr_state), 0);
        chk("t5_ready", int'(alu_ready), 0);
        pwr_req = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);

        // 6: random request/busy traffic checked by the model every cycle
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 19) == 0) pwr_req = ~pwr_req;
            alu_busy = ($urandom_range(0, 3) == 0);
            step(1);
        end
        pwr_req  = 1'b0;
        alu_busy = 1'b0;
        step(40);
        @(negedge clk);
        #1;
        chk("done_count", dut_done_cnt, m_completions);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
